// File: rtl/parity_rx_checker.sv
// Serial receive-side parity checker: deserialises DATA_W bits (LSB first) plus a
// parity bit, reports the word, the parity result and a saturating error count.
module parity_rx_checker #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count,
  output logic              abort_flag
);

  localparam int   CW      = $clog2(DATA_W + 1);
  localparam logic ODD_BIT = (ODD != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              acc_reg, acc_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] data_out_reg, data_out_next;
  logic              data_valid_reg, data_valid_next;
  logic              parity_err_reg, parity_err_next;
  logic              busy_reg, busy_next;
  logic [CNT_W-1:0]  err_count_reg, err_count_next;
  logic              abort_reg, abort_next;
  logic              start;
  logic              frame_err;

  assign start     = bit_valid & sof;
  assign frame_err = acc_reg ^ bit_in ^ ODD_BIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      acc_reg        <= 1'b0;
      shift_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      busy_reg       <= 1'b0;
      err_count_reg  <= '0;
      abort_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      acc_reg        <= acc_next;
      shift_reg      <= shift_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      parity_err_reg <= parity_err_next;
      busy_reg       <= busy_next;
      err_count_reg  <= err_count_next;
      abort_reg      <= abort_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    acc_next        = acc_reg;
    shift_next      = shift_reg;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    parity_err_next = parity_err_reg;
    err_count_next  = err_count_reg;
    abort_next      = 1'b0;

    if (start) begin
      // A sof always begins a fresh frame; anything in flight is dropped.
      abort_next    = (state_reg != IDLE);
      shift_next    = '0;
      shift_next[0] = bit_in;
      acc_next      = bit_in;
      count_next    = CW'(1);
      state_next    = DATA;
    end else if (bit_valid) begin
      case (state_reg)
        DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (count_reg == CW'(i)) shift_next[i] = bit_in;
          end
          acc_next   = acc_reg ^ bit_in;
          count_next = count_reg + CW'(1);
          if (count_next == CW'(DATA_W)) state_next = PARITY;
        end
        PARITY: begin
          data_out_next   = shift_reg;
          parity_err_next = frame_err;
          data_valid_next = 1'b1;
          if (frame_err && (err_count_reg != {CNT_W{1'b1}}))
            err_count_next = err_count_reg + CNT_W'(1);
          count_next = '0;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign parity_err = parity_err_reg;
  assign busy       = busy_reg;
  assign err_count  = err_count_reg;
  assign abort_flag = abort_reg;

endmodule

// File: tb/tb_parity_rx_checker.sv
// Bench: two instances (even/16-bit counter, odd/2-bit counter) share one bit stream
// and are checked every cycle against a queue-based frame model.
module tb_parity_rx_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_in = 1'b0, bit_valid = 1'b0, sof = 1'b0;

  logic [7:0]  a_dout, b_dout;
  logic        a_dv, b_dv, a_perr, b_perr, a_busy, b_busy, a_abort, b_abort;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  parity_rx_checker #(.DATA_W(8), .ODD(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .data_out(a_dout), .data_valid(a_dv), .parity_err(a_perr), .busy(a_busy),
    .err_count(a_cnt), .abort_flag(a_abort));

  parity_rx_checker #(.DATA_W(8), .ODD(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .data_out(b_dout), .data_valid(b_dv), .parity_err(b_perr), .busy(b_busy),
    .err_count(b_cnt), .abort_flag(b_abort));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: bits of the current frame live in a queue; a frame is complete
  // when a bit arrives with the queue already holding 8 data bits.
  bit          q[$];
  logic [7:0]  m_dout;
  logic        m_dv, m_abort, m_busy;
  logic        m_perr[2];
  int          m_cnt[2];
  int          m_odd[2] = '{0, 1};
  int          m_max[2] = '{65535, 3};

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_dout = '0; m_dv = 0; m_abort = 0; m_busy = 0;
        for (int k = 0; k < 2; k++) begin m_perr[k] = 0; m_cnt[k] = 0; end
      end else begin
        m_dv = 0; m_abort = 0;
        if (bit_valid) begin
          if (sof) begin
            if (q.size() != 0) m_abort = 1;
            q = {bit'(bit_in)};
          end else if (q.size() == 8) begin
            int ones;
            for (int i = 0; i < 8; i++) m_dout[i] = q[i];
            ones = $countones(m_dout) + int'(bit_in);
            for (int k = 0; k < 2; k++) begin
              m_perr[k] = ((ones % 2) != m_odd[k]);
              if (m_perr[k] && m_cnt[k] < m_max[k]) m_cnt[k]++;
            end
            m_dv = 1;
            q.delete();
          end else if (q.size() != 0) begin
            q.push_back(bit_in);
          end
        end
        m_busy = (q.size() != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_data_out", 32'(a_dout), 32'(m_dout));
      chk("a_data_valid", 32'(a_dv), 32'(m_dv));
      chk("a_parity_err", 32'(a_perr), 32'(m_perr[0]));
      chk("a_busy", 32'(a_busy), 32'(m_busy));
      chk("a_err_count", 32'(a_cnt), 32'(m_cnt[0]));
      chk("a_abort", 32'(a_abort), 32'(m_abort));
      chk("b_data_out", 32'(b_dout), 32'(m_dout));
      chk("b_data_valid", 32'(b_dv), 32'(m_dv));
      chk("b_parity_err", 32'(b_perr), 32'(m_perr[1]));
      chk("b_busy", 32'(b_busy), 32'(m_busy));
      chk("b_err_count", 32'(b_cnt), 32'(m_cnt[1]));
      chk("b_abort", 32'(b_abort), 32'(m_abort));
    end
  end

  task automatic send_bit(input logic b, input logic s);
    bit_in = b; bit_valid = 1'b1; sof = s;
    @(negedge clk);
    bit_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic p, input int stalls);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], i == 0);
      repeat (stalls) @(negedge clk);
    end
    send_bit(p, 1'b0);
    $display("[TB] frame %02h parity %0b stalls %0d -> a:%02h/%0b/%0d b:%02h/%0b/%0d",
             w, p, stalls, a_dout, a_perr, a_cnt, b_dout, b_perr, b_cnt);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data_out", 32'(a_dout), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_err_count", 32'(a_cnt), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // sof without bit_valid is ignored
    sof = 1'b1; bit_in = 1'b1; @(negedge clk); sof = 1'b0;
    chk("sof_no_valid_busy", 32'(a_busy), 32'h0);

    send_frame(8'hA5, 1'b0, 0);
    chk("a5_even_dv", 32'(a_dv), 32'h1);
    chk("a5_even_dout", 32'(a_dout), 32'hA5);
    chk("a5_even_perr", 32'(a_perr), 32'h0);
    chk("a5_even_cnt", 32'(a_cnt), 32'h0);
    idle(1);
    chk("dv_one_cycle", 32'(a_dv), 32'h0);
    chk("dout_holds", 32'(a_dout), 32'hA5);

    send_frame(8'hA5, 1'b1, 0);
    chk("a5_bad_perr", 32'(a_perr), 32'h1);
    chk("a5_bad_cnt", 32'(a_cnt), 32'h1);
    for (int n = 0; n < 3; n++) send_frame(8'hA5, 1'b1, 0);
    chk("four_bad_cnt", 32'(a_cnt), 32'h4);

    send_frame(8'h00, 1'b1, 0);
    chk("odd_00_p1_perr", 32'(b_perr), 32'h0);
    send_frame(8'h00, 1'b0, 0);
    chk("odd_00_p0_perr", 32'(b_perr), 32'h1);
    idle(1);

    send_bit(1'b0, 1'b1);
    idle(2);
    chk("stall_busy", 32'(a_busy), 32'h1);
    for (int i = 1; i < 8; i++) begin
      send_bit(((8'h3C >> i) & 8'h1) != 0, 1'b0);
      idle(2);
    end
    send_bit(1'b0, 1'b0);
    chk("stall_dout", 32'(a_dout), 32'h3C);
    chk("stall_perr", 32'(a_perr), 32'h0);
    idle(1);

    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    send_bit(1'b1, 1'b1);
    chk("abort_pulse", 32'(a_abort), 32'h1);
    chk("abort_no_dv", 32'(a_dv), 32'h0);
    for (int i = 1; i < 8; i++) begin
      send_bit(1'b1, 1'b0);
      if (i == 1) chk("abort_one_cycle", 32'(a_abort), 32'h0);
    end
    send_bit(1'b0, 1'b0);
    chk("ff_dout", 32'(a_dout), 32'hFF);
    chk("ff_perr", 32'(a_perr), 32'h0);
    $display("[TB] abort then 0xFF -> a:%02h/%0b", a_dout, a_perr);

    send_frame(8'h00, 1'b0, 0);
    send_frame(8'h00, 1'b0, 0);
    chk("b_saturated", 32'(b_cnt), 32'h3);
    idle(1);

    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 32'(a_dout), 32'h0);
    chk("async_rst_busy", 32'(a_busy), 32'h0);
    chk("async_rst_cnt", 32'(a_cnt), 32'h0);
    chk("async_rst_b_cnt", 32'(b_cnt), 32'h0);
    chk("async_rst_perr", 32'(b_perr), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    idle(1);
    send_frame(8'h81, 1'b0, 0);
    chk("post_rst_dout", 32'(a_dout), 32'h81);
    chk("post_rst_perr", 32'(a_perr), 32'h0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_rx_checker.md
Name: parity_rx_checker

Overview:
- Serial receive-side parity checker; counterpart of the team's XOR-based parity generator/transmitter.
- Deserialises a framed bit stream of DATA_W data bits (LSB first) followed by one parity bit.
- Accumulates XOR parity, presents the recovered word, flags parity errors and keeps a saturating error count.
- Sits between a serial link front end and the word-level consumer.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 2..32)
ODD, 0, 0 = even parity expected, 1 = odd parity expected
CNT_W, 16, width of error counter

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
bit_in  input  1  serial bit, sampled only when bit_valid=1
bit_valid  input  1  bit_in carries a valid bit this cycle
sof  input  1  start of frame, qualified by bit_valid; marks the first data bit
data_out  output  DATA_W  last completed frame word, bit 0 = first received bit
data_valid  output  1  one-cycle pulse, frame complete
parity_err  output  1  parity result of last completed frame, 1 = mismatch
busy  output  1  high while in DATA or PARITY state
err_count  output  CNT_W  saturating count of frames with parity_err=1
abort_flag  output  1  one-cycle pulse, in-progress frame abandoned by a new sof

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate): state=IDLE, bit counter=0, acc=0, shift reg=0, data_out=0, data_valid=0, parity_err=0, busy=0, err_count=0, abort_flag=0. Reset mid-frame discards the frame with no pulses.
- States:
  - IDLE: bit_valid=0 or sof=0 -> stay, bits ignored. bit_valid & sof -> capture bit_in as data bit 0, acc=bit_in, count=1, go DATA.
  - DATA: on bit_valid & ~sof, shift in at position count, acc ^= bit_in, count++. When count reaches DATA_W, go PARITY. Cycles with bit_valid=0 are stalls; state unchanged.
  - PARITY: on bit_valid & ~sof, this bit is parity. At that edge: data_out <= shifted word, parity_err <= acc ^ bit_in ^ ODD, data_valid <= 1, state -> IDLE, count <= 0.
- Frame completes one clock after the parity bit is accepted. The clock edge that samples the parity bit registers data_valid=1.
- data_valid and abort_flag are high for exactly one cycle. data_out and parity_err hold until the next completed frame.
- err_count increments by 1 in the same edge as a data_valid with parity_err=1. It saturates at 2^CNT_W-1 and never wraps.
- sof with bit_valid while in DATA or PARITY:
  - abort_flag pulses next cycle.
  - The partial frame is discarded: no data_valid, err_count unchanged.
  - The sof bit starts a new frame: count=1, acc=bit_in, state DATA.
- sof without bit_valid is ignored in every state.
- busy = (state != IDLE), registered.
- The accumulator is a pure XOR reduction over data bits. No other arithmetic.

Test Plan:
- Even parity, DATA_W=8: sof+bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), then parity 0, bit_valid continuous -> data_valid pulses 1 cycle after parity bit, data_out=0xA5, parity_err=0, err_count=0.
- Same frame, parity bit 1 -> data_out=0xA5, parity_err=1, err_count=1. Send 3 more bad frames -> err_count=4.
- ODD=1: 0x00 with parity 1 -> parity_err=0; 0x00 with parity 0 -> parity_err=1.
- Stalls: 0x3C frame with bit_valid deasserted for 2 cycles between every bit -> result identical to the continuous case (data_out=0x3C, parity_err=0), busy high throughout the frame.
- Abort: sof, 4 data bits, then sof+new 0xFF frame with parity 0 -> abort_flag single pulse, no data_valid for the first frame; then data_out=0xFF, parity_err=0.
- Reset: assert rst_n=0 asynchronously after 5 data bits -> all outputs 0 immediately. After release, a clean frame 0x81/parity 0 -> data_out=0x81, no stale bits. Saturation: CNT_W=2, 5 bad frames -> err_count=3.
